// File: rtl/ram_8x8_if.sv
// Bus for the 8x8 register-file RAM: write data/address/enable in, read data out.
// The same address serves both the synchronous write and the combinational read.
interface ram_8x8_if;
  logic [7:0] D;
  logic [7:0] Q;
  logic [2:0] addr;
  logic [0:0] we;

  modport master (output D, output addr, output we, input Q);
  modport slave  (input D, input addr, input we, output Q);
endinterface

// File: rtl/ram_8x8.sv
// 8-word x 8-bit flop RAM: write lands on the rising edge, read is combinational (zero latency).
// No backpressure: a write is accepted every cycle; reset beats a same-cycle write.
module ram_8x8 (
  input  logic     clk,
  input  logic     rst,
  ram_8x8_if.slave bus
);

  logic [7:0] mem [8];
  logic [7:0] word_wen;

  // 3-to-8 decoder: one-hot write strobe for the addressed word
  always_comb begin
    word_wen = 8'h00;
    if (bus.we[0]) begin
      word_wen[bus.addr] = 1'b1;
    end
  end

  for (genvar w = 0; w < 8; w++) begin : g_word
    always_ff @(posedge clk) begin
      if (rst) begin
        mem[w] <= 8'h00;
      end else if (word_wen[w]) begin
        mem[w] <= bus.D;
      end
    end
  end

  // Unregistered read mux, so a write is visible straight after its edge
  assign bus.Q = mem[bus.addr];

endmodule

// File: tb/tb_ram_8x8.sv
// Directed checks for ram_8x8: reset clear, write/read, enable gating, sweeps,
// reset priority and read-during-write.
module tb_ram_8x8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ram_8x8_if bus ();

  ram_8x8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] exp);
    total++;
    assert (bus.Q === exp)
    else begin
      bad++;
      $error("FAIL %s: Q=%h expected %h", tag, bus.Q, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    bus.addr = a;
    #1;
    chk(tag, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.D    = d;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.we  = 1'b0;
    bus.D   = 8'h00;
    bus.addr = 3'd0;

    // Reset clear
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) rd($sformatf("rst_clear_%0d", i), 3'(i), 8'h00);

    // Basic write/read
    wr(3'd0, 8'hFF);
    wr(3'd1, 8'h01);
    rd("basic_a0", 3'd0, 8'hFF);
    rd("basic_a1", 3'd1, 8'h01);
    rd("basic_a0_again", 3'd0, 8'hFF);

    // Write-enable gating
    bus.we   = 1'b0;
    bus.D    = 8'hA5;
    bus.addr = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("gate_a1", 8'h01);
    rd("gate_a0", 3'd0, 8'hFF);
    for (int i = 2; i < 8; i++) rd($sformatf("gate_other_%0d", i), 3'(i), 8'h00);

    // Full sweep, then inverted data
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) rd($sformatf("sweep_%0d", i), 3'(i), 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) wr(3'(i), ~8'(8'h10 + i));
    for (int i = 0; i < 8; i++) rd($sformatf("sweep_inv_%0d", i), 3'(i), ~8'(8'h10 + i));

    // Reset has priority over a same-cycle write
    rst      = 1'b1;
    bus.we   = 1'b1;
    bus.D    = 8'h3C;
    bus.addr = 3'd5;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bus.we = 1'b0;
    for (int i = 0; i < 8; i++) rd($sformatf("rst_prio_%0d", i), 3'(i), 8'h00);
    wr(3'd5, 8'h3C);
    rd("post_rst_wr5", 3'd5, 8'h3C);

    // Read-during-write on the same address
    wr(3'd1, 8'h11);
    wr(3'd2, 8'h12);
    wr(3'd3, 8'h33);
    bus.addr = 3'd2;
    bus.D    = 8'h77;
    bus.we   = 1'b1;
    #1;
    chk("rdw_before", 8'h12);
    @(posedge clk);
    #1;
    chk("rdw_after", 8'h77);
    bus.we = 1'b0;
    rd("rdw_a1", 3'd1, 8'h11);
    rd("rdw_a3", 3'd3, 8'h33);
    rd("rdw_a2_hold", 3'd2, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
